// File: rtl/axi_id_throttle.sv
// axi_id_throttle: limits outstanding AXI address transactions per ID and in total.
// Responses pass straight through and retire outstanding transactions.
// A RUN/DRAIN/HALT FSM lets new issues be stopped while the remaining
// transactions complete.
// Ports:
//   axi4_mm_clk, axi4_mm_rst_n    - clock, async active-low reset
//   enable, clear_counters        - run request, sync clear of the status counters
//   slave_aX*  / master_aX*       - address channel, upstream / downstream
//   slave_X*   / master_X*        - response channel, upstream / downstream
//   quiesced, total_outstanding   - HALT indication, current outstanding total
//   stall_cycles, unexpected_rsp  - blocked-address cycle count, orphan-response flag
module axi_id_throttle #(
   parameter int unsigned ID_W       = 5,
   parameter int unsigned MID_W      = 12,
   parameter int unsigned MAX_PER_ID = 1,
   parameter int unsigned MAX_TOTAL  = 16,
   parameter int unsigned USE_LAST   = 1,
   parameter int unsigned CNT_W      = 32
) (
   input  logic             axi4_mm_clk,
   input  logic             axi4_mm_rst_n,
   input  logic             enable,
   input  logic             clear_counters,
   input  logic             slave_aXvalid,
   output logic             slave_aXready,
   input  logic [ID_W-1:0]  slave_aXid,
   output logic             slave_Xvalid,
   input  logic             slave_Xready,
   output logic [ID_W-1:0]  slave_Xid,
   output logic             slave_Xlast,
   output logic             master_aXvalid,
   input  logic             master_aXready,
   output logic [MID_W-1:0] master_aXid,
   input  logic             master_Xvalid,
   output logic             master_Xready,
   input  logic [MID_W-1:0] master_Xid,
   input  logic             master_Xlast,
   output logic             quiesced,
   output logic [7:0]       total_outstanding,
   output logic [CNT_W-1:0] stall_cycles,
   output logic             unexpected_rsp
);

   localparam int unsigned N_ID = 1 << ID_W;

   typedef enum logic [1:0] {
      ST_HALT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [3:0]        r_cnt [N_ID];
   logic [7:0]        r_tot;
   logic [CNT_W-1:0]  r_stall;
   logic              r_unexp;

   logic              w_ok;
   logic              w_issue;
   logic              w_retire;
   logic              w_dec;
   logic [ID_W-1:0]   w_rsp_id;
   logic [N_ID-1:0]   w_inc_vec;
   logic [N_ID-1:0]   w_dec_vec;
   logic              w_unused_xid;

   // Address gating: only in RUN and while both limits have headroom
   assign w_ok = (r_state == ST_RUN) &&
                 (r_cnt[slave_aXid] < 4'(MAX_PER_ID)) &&
                 (r_tot < 8'(MAX_TOTAL));

   assign master_aXvalid = slave_aXvalid & w_ok;
   assign slave_aXready  = master_aXready & w_ok;
   assign master_aXid    = MID_W'(slave_aXid);

   // Response path is transparent in every state so a drain can always finish
   assign slave_Xvalid  = master_Xvalid;
   assign master_Xready = slave_Xready;
   assign slave_Xid     = master_Xid[ID_W-1:0];
   assign slave_Xlast   = master_Xlast;
   assign w_rsp_id      = master_Xid[ID_W-1:0];
   assign w_unused_xid  = ^master_Xid;

   assign w_issue  = master_aXvalid & master_aXready;
   assign w_retire = master_Xvalid & master_Xready & (master_Xlast | (USE_LAST == 0));
   // A retire on an idle ID is flagged, never applied (no underflow)
   assign w_dec    = w_retire & (r_cnt[w_rsp_id] != 4'd0);

   assign w_inc_vec = w_issue ? (N_ID'(1) << slave_aXid) : '0;
   assign w_dec_vec = w_dec   ? (N_ID'(1) << w_rsp_id)   : '0;

   // FSM state register
   always_ff @(posedge axi4_mm_clk or negedge axi4_mm_rst_n) begin
      if (!axi4_mm_rst_n) r_state <= ST_HALT;
      else                r_state <= w_state_nxt;
   end

   // FSM next state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_HALT:  if (enable) w_state_nxt = ST_RUN;
         ST_RUN:   if (!enable) w_state_nxt = ST_DRAIN;
         ST_DRAIN: begin
            if (enable)              w_state_nxt = ST_RUN;
            else if (r_tot == 8'd0)  w_state_nxt = ST_HALT;
         end
         default:  w_state_nxt = ST_HALT;
      endcase
   end

   // Per-ID and total outstanding counters; issue+retire in one cycle cancel
   always_ff @(posedge axi4_mm_clk or negedge axi4_mm_rst_n) begin
      if (!axi4_mm_rst_n) begin
         for (int i = 0; i < N_ID; i++) r_cnt[i] <= 4'd0;
         r_tot <= 8'd0;
      end else begin
         for (int i = 0; i < N_ID; i++) begin
            if (w_inc_vec[i] && !w_dec_vec[i])      r_cnt[i] <= r_cnt[i] + 4'd1;
            else if (w_dec_vec[i] && !w_inc_vec[i]) r_cnt[i] <= r_cnt[i] - 4'd1;
         end
         case ({w_issue, w_dec})
            2'b10:   r_tot <= r_tot + 8'd1;
            2'b01:   r_tot <= r_tot - 8'd1;
            default: r_tot <= r_tot;
         endcase
      end
   end

   // Status: saturating stall counter and sticky unexpected-response flag
   always_ff @(posedge axi4_mm_clk or negedge axi4_mm_rst_n) begin
      if (!axi4_mm_rst_n) begin
         r_stall <= '0;
         r_unexp <= 1'b0;
      end else if (clear_counters) begin
         r_stall <= '0;
         r_unexp <= 1'b0;
      end else begin
         if (slave_aXvalid && !slave_aXready && !(&r_stall))
            r_stall <= r_stall + CNT_W'(1);
         if (w_retire && (r_cnt[w_rsp_id] == 4'd0))
            r_unexp <= 1'b1;
      end
   end

   assign quiesced          = (r_state == ST_HALT);
   assign total_outstanding = r_tot;
   assign stall_cycles      = r_stall;
   assign unexpected_rsp    = r_unexp;

endmodule

// File: tb/tb_axi_id_throttle.sv
// Directed bench for axi_id_throttle. u_dut uses default parameters;
// u_dut2 (MAX_PER_ID=2, CNT_W=4) shares all inputs and covers the
// same-cycle issue/retire case and stall counter saturation.
module tb_axi_id_throttle;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable, clear_counters;
   logic        s_avalid;
   logic [4:0]  s_aid;
   logic        s_xready;
   logic        m_aready;
   logic        m_xvalid;
   logic [11:0] m_xid;
   logic        m_xlast;

   logic        s_aready, s_xvalid, s_xlast, m_avalid, m_xready, quiesced, unexp;
   logic [4:0]  s_xid;
   logic [11:0] m_aid;
   logic [7:0]  tot;
   logic [31:0] stall;

   logic        s_aready2, s_xvalid2, s_xlast2, m_avalid2, m_xready2, quiesced2, unexp2;
   logic [4:0]  s_xid2;
   logic [11:0] m_aid2;
   logic [7:0]  tot2;
   logic [3:0]  stall2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   axi_id_throttle u_dut (
      .axi4_mm_clk(clk), .axi4_mm_rst_n(rst_n), .enable(enable), .clear_counters(clear_counters),
      .slave_aXvalid(s_avalid), .slave_aXready(s_aready), .slave_aXid(s_aid),
      .slave_Xvalid(s_xvalid), .slave_Xready(s_xready), .slave_Xid(s_xid), .slave_Xlast(s_xlast),
      .master_aXvalid(m_avalid), .master_aXready(m_aready), .master_aXid(m_aid),
      .master_Xvalid(m_xvalid), .master_Xready(m_xready), .master_Xid(m_xid), .master_Xlast(m_xlast),
      .quiesced(quiesced), .total_outstanding(tot), .stall_cycles(stall), .unexpected_rsp(unexp)
   );

   axi_id_throttle #(.MAX_PER_ID(2), .CNT_W(4)) u_dut2 (
      .axi4_mm_clk(clk), .axi4_mm_rst_n(rst_n), .enable(enable), .clear_counters(clear_counters),
      .slave_aXvalid(s_avalid), .slave_aXready(s_aready2), .slave_aXid(s_aid),
      .slave_Xvalid(s_xvalid2), .slave_Xready(s_xready), .slave_Xid(s_xid2), .slave_Xlast(s_xlast2),
      .master_aXvalid(m_avalid2), .master_aXready(m_aready), .master_aXid(m_aid2),
      .master_Xvalid(m_xvalid), .master_Xready(m_xready2), .master_Xid(m_xid), .master_Xlast(m_xlast),
      .quiesced(quiesced2), .total_outstanding(tot2), .stall_cycles(stall2), .unexpected_rsp(unexp2)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rsp(input logic v, input logic [11:0] id, input logic last);
      m_xvalid = v;
      m_xid    = id;
      m_xlast  = last;
   endtask

   initial begin
      rst_n = 1'b0; enable = 1'b0; clear_counters = 1'b0;
      s_avalid = 1'b1; s_aid = 5'd3; s_xready = 1'b1; m_aready = 1'b1;
      rsp(1'b1, 12'hABC, 1'b1);
      #1;
      // Reset state and transparent responses while in reset
      chk("rst_quiesced", quiesced, 1);
      chk("rst_tot", tot, 0);
      chk("rst_stall", stall, 0);
      chk("rst_unexp", unexp, 0);
      chk("rst_m_avalid", m_avalid, 0);
      chk("rst_s_aready", s_aready, 0);
      chk("rst_s_xvalid", s_xvalid, 1);
      chk("rst_s_xid", s_xid, 5'h1C);
      chk("rst_s_xlast", s_xlast, 1);
      chk("rst_m_xready", m_xready, 1);
      tick(); tick();
      s_avalid = 1'b0; rsp(1'b0, 12'h000, 1'b0);
      rst_n = 1'b1;
      tick();
      chk("halt_hold", quiesced, 1);
      enable = 1'b1;
      tick();
      chk("halt_to_run", quiesced, 0);

      // Per-ID limit: second ID 3 stalls until ID 3 retires
      s_avalid = 1'b1; s_aid = 5'd3;
      #1;
      chk("id3_first_ready", s_aready, 1);
      chk("id3_first_valid", m_avalid, 1);
      chk("id3_mid", m_aid, 12'h003);
      tick();
      chk("id3_tot1", tot, 1);
      chk("id3_blocked_ready", s_aready, 0);
      chk("id3_blocked_valid", m_avalid, 0);
      chk("id3_stall0", stall, 0);
      tick();
      chk("id3_stall1", stall, 1);
      tick(); tick();
      chk("id3_stall3", stall, 3);
      rsp(1'b1, 12'h003, 1'b1);
      tick();
      chk("id3_retire_tot", tot, 0);
      chk("id3_stall4", stall, 4);
      rsp(1'b0, 12'h000, 1'b0);
      #1;
      chk("id3_second_ready", s_aready, 1);
      tick();
      chk("id3_second_tot", tot, 1);
      chk("id3_stall_hold", stall, 4);
      s_avalid = 1'b0;
      rsp(1'b1, 12'h003, 1'b1);
      tick();
      chk("id3_final_tot", tot, 0);
      chk("unexp_still0", unexp, 0);

      // Orphan response on ID 9, then clear has priority over a new orphan
      rsp(1'b1, 12'h009, 1'b1);
      tick();
      chk("orphan_unexp", unexp, 1);
      chk("orphan_tot", tot, 0);
      clear_counters = 1'b1;
      tick();
      chk("clear_unexp", unexp, 0);
      chk("clear_stall", stall, 0);
      clear_counters = 1'b0;
      rsp(1'b0, 12'h000, 1'b0);

      // Total limit: 16 IDs fill the budget, ID 16 waits for one retire
      s_avalid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         s_aid = 5'(i);
         tick();
      end
      chk("full_tot", tot, 16);
      s_aid = 5'd16;
      rsp(1'b1, 12'h000, 1'b1);
      #1;
      chk("full_blocked", s_aready, 0);
      chk("full_m_avalid", m_avalid, 0);
      chk("id16_mid", m_aid, 12'h010);
      tick();
      chk("full_retire_tot", tot, 15);
      rsp(1'b0, 12'h000, 1'b0);
      #1;
      chk("id16_ready", s_aready, 1);
      tick();
      chk("id16_tot", tot, 16);
      s_avalid = 1'b0;
      for (int i = 1; i < 15; i++) begin
         rsp(1'b1, 12'(i), 1'b1);
         tick();
      end
      chk("two_left", tot, 2);

      // Drain with two outstanding, then back to RUN
      rsp(1'b0, 12'h000, 1'b0);
      enable = 1'b0;
      tick();
      chk("drain_not_quiesced", quiesced, 0);
      s_avalid = 1'b1; s_aid = 5'd20;
      rsp(1'b1, 12'h00F, 1'b1);
      #1;
      chk("drain_no_issue", m_avalid, 0);
      chk("drain_rsp_pass", s_xvalid, 1);
      s_avalid = 1'b0;
      tick();
      chk("drain_tot1", tot, 1);
      rsp(1'b1, 12'h010, 1'b1);
      tick();
      chk("drain_tot0", tot, 0);
      chk("drain_still", quiesced, 0);
      rsp(1'b0, 12'h000, 1'b0);
      tick();
      chk("drain_halt", quiesced, 1);
      enable = 1'b1;
      tick();
      chk("rerun", quiesced, 0);
      s_avalid = 1'b1;
      #1;
      chk("rerun_issue", m_avalid, 1);
      tick();
      chk("rerun_tot", tot, 1);
      s_avalid = 1'b0;
      rsp(1'b1, 12'h014, 1'b1);
      tick();
      chk("rerun_retire", tot, 0);

      // Burst retire only on the last beat; upper response ID bits ignored
      rsp(1'b0, 12'h000, 1'b0);
      s_avalid = 1'b1; s_aid = 5'd2;
      tick();
      chk("burst_issue", tot, 1);
      for (int b = 0; b < 3; b++) begin
         rsp(1'b1, 12'h002, 1'b0);
         #1;
         chk("burst_blocked", s_aready, 0);
         tick();
      end
      chk("burst_no_retire", tot, 1);
      rsp(1'b1, 12'hFE2, 1'b1);
      #1;
      chk("burst_s_xid", s_xid, 5'h02);
      tick();
      chk("burst_retired", tot, 0);
      rsp(1'b0, 12'h000, 1'b0);
      #1;
      chk("burst_id2_free", s_aready, 1);
      chk("burst_mid", m_aid, 12'h002);
      s_avalid = 1'b0; s_aid = 5'd31;
      #1;
      chk("mid_upper_zero", m_aid, 12'h01F);

      // Reset mid-operation discards outstanding; late response is an orphan
      s_avalid = 1'b1; s_aid = 5'd7;
      tick();
      chk("pre_rst_tot", tot, 1);
      s_avalid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("async_rst_tot", tot, 0);
      chk("async_rst_quiesced", quiesced, 1);
      tick();
      rst_n = 1'b1; enable = 1'b0;
      rsp(1'b1, 12'h007, 1'b1);
      tick();
      chk("late_rsp_unexp", unexp, 1);
      chk("late_rsp_tot", tot, 0);
      rsp(1'b0, 12'h000, 1'b0);

      // Stall counting in HALT; 4-bit counter saturates
      s_avalid = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      chk("stall_count20", stall, 20);
      chk("stall_saturate", stall2, 4'hF);
      s_avalid = 1'b0;

      // Same-cycle issue/retire on one ID, and on different IDs (MAX_PER_ID=2)
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1; enable = 1'b1;
      tick();
      s_avalid = 1'b1; s_aid = 5'd5;
      tick();
      chk("same_pre_tot", tot2, 1);
      rsp(1'b1, 12'h005, 1'b1);
      #1;
      chk("same_ready", s_aready2, 1);
      tick();
      chk("same_tot", tot2, 1);
      rsp(1'b0, 12'h000, 1'b0);
      #1;
      chk("same_cnt_room", s_aready2, 1);
      tick();
      chk("same_tot2", tot2, 2);
      chk("same_cnt_full", s_aready2, 0);
      s_aid = 5'd6;
      rsp(1'b1, 12'h005, 1'b1);
      #1;
      chk("diff_ready", s_aready2, 1);
      tick();
      chk("diff_tot", tot2, 2);
      rsp(1'b0, 12'h000, 1'b0);
      s_avalid = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/axi_id_throttle.md
AXI_ID_THROTTLE -- requirements
Module: axi_id_throttle

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- ID_W, 5, slave-side ID width; 2**ID_W tracked IDs.
- MID_W, 12, master-side ID width; must be >= ID_W.
- MAX_PER_ID, 1, maximum outstanding transactions per ID (1..15).
- MAX_TOTAL, 16, maximum outstanding transactions across all IDs (1..255).
- USE_LAST, 1, 1 = retire on a response beat with last=1; 0 = retire on every response beat.
- CNT_W, 32, stall counter width.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- axi4_mm_clk, in, 1, the single clock.
- axi4_mm_rst_n, in, 1, reset, asynchronous, active-low.
- enable, in, 1, run request; deassertion starts a drain.
- clear_counters, in, 1, synchronous clear of stall_cycles and unexpected_rsp.
- slave_aXvalid / slave_aXready, in / out, 1 each, upstream address handshake.
- slave_aXid, in, ID_W, upstream address ID.
- slave_Xvalid / slave_Xready, out / in, 1 each, upstream response handshake.
- slave_Xid, out, ID_W, upstream response ID.
- slave_Xlast, out, 1, upstream response last.
- master_aXvalid / master_aXready, out / in, 1 each, downstream address handshake.
- master_aXid, out, MID_W, downstream address ID.
- master_Xvalid / master_Xready, in / out, 1 each, downstream response handshake.
- master_Xid, in, MID_W, downstream response ID.
- master_Xlast, in, 1, downstream response last.
- quiesced, out, 1, high in HALT state.
- total_outstanding, out, 8, current outstanding count.
- stall_cycles, out, CNT_W, count of cycles with an address blocked.
- unexpected_rsp, out, 1, sticky flag for a retire on an ID with zero outstanding.

Function
REQ-003 The block SHALL keep a per-ID outstanding counter cnt[i] (4 bits) and a total counter tot (8 bits).
REQ-004 FSM states SHALL be RUN, DRAIN and HALT; reset state is HALT.
- HALT -> RUN when enable=1.
- RUN -> DRAIN when enable=0.
- DRAIN -> RUN when enable=1.
- DRAIN -> HALT when enable=0 and tot==0 in the same cycle.
REQ-005 Define ok = (state==RUN) & (cnt[slave_aXid] < MAX_PER_ID) & (tot < MAX_TOTAL). Outputs SHALL be combinational: master_aXvalid = slave_aXvalid & ok; slave_aXready = master_aXready & ok.
REQ-006 master_aXid SHALL carry slave_aXid in [ID_W-1:0] and zero in the upper bits.
REQ-007 An issue SHALL occur on master_aXvalid & master_aXready and increment cnt[slave_aXid] and tot on the next clock edge.
REQ-008 A retire SHALL occur on master_Xvalid & master_Xready & (master_Xlast | !USE_LAST).
- It decrements cnt[master_Xid[ID_W-1:0]] and tot.
- The upper master_Xid bits are ignored.
REQ-009 Responses SHALL pass straight through in all states.
- slave_Xvalid = master_Xvalid; master_Xready = slave_Xready.
- slave_Xid = master_Xid[ID_W-1:0]; slave_Xlast = master_Xlast.
- Responses are not gated by enable, so a drain always completes.
REQ-010 Issue and retire on the same ID in the same cycle SHALL leave cnt unchanged; issue and retire on different IDs in the same cycle SHALL leave tot unchanged.
REQ-011 A retire on an ID with cnt==0 SHALL leave cnt and tot unchanged (no underflow) and set unexpected_rsp on the next cycle.
REQ-012 Counters SHALL never exceed MAX_PER_ID or MAX_TOTAL; the gating in REQ-005 guarantees this.
REQ-013 stall_cycles SHALL increment by 1 on each cycle with slave_aXvalid=1 and slave_aXready=0, saturate at all-ones, and clear to 0 the cycle after clear_counters=1. clear_counters takes priority over increment and over setting unexpected_rsp.
REQ-014 quiesced SHALL be registered-state-derived: quiesced = (state==HALT).
REQ-015 total_outstanding SHALL equal tot.

Reset
REQ-016 Asserting axi4_mm_rst_n low SHALL immediately, without a clock, set:
- state = HALT;
- all cnt = 0, tot = 0;
- stall_cycles = 0, unexpected_rsp = 0.
REQ-017 Therefore, while in reset: quiesced=1, master_aXvalid=0, slave_aXready=0, and the response path stays transparent.
REQ-018 Reset in mid-operation SHALL discard all outstanding state. Responses arriving after reset for pre-reset issues SHALL set unexpected_rsp.
REQ-019 Reset deassertion SHALL be synchronised by the integrator; the first clock edge after release may transition HALT->RUN.

Verification
REQ-020 Reset, then enable=1, then issue ID 3 twice with MAX_PER_ID=1 -> first accepted; second stalls with slave_aXready=0; stall_cycles increments each cycle until a response for ID 3 with last=1 retires it.
REQ-021 Issue IDs 0..15 with MAX_TOTAL=16, then offer ID 16 -> blocked, tot=16; one retire then lets ID 16 issue next cycle.
REQ-022 Same-cycle issue of ID 5 and retire of ID 5 (cnt[5]=1, MAX_PER_ID=2) -> cnt[5] stays 1, tot unchanged.
REQ-023 With 2 transactions outstanding, drop enable -> DRAIN, no new issues, responses pass; after the second retire, quiesced=1 next cycle; raising enable returns to RUN.
REQ-024 Response on ID 9 with cnt[9]=0 -> unexpected_rsp=1 and tot unchanged; clear_counters=1 -> unexpected_rsp=0 and stall_cycles=0.
REQ-025 USE_LAST=1, 4-beat read burst on ID 2 with last only on beat 4 -> cnt[2] decrements only after beat 4; master_aXid upper 7 bits are 0 throughout.
